// File: rtl/cpu_pkg.sv
// Types and constants shared by the CPU core and its program loader.
// Holds the loader FSM encoding, the frame marker and the opcode set.
package cpu_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_LD,
    OP_ST,
    OP_BEQ,
    OP_JMP
  } opcode_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: parses a framed image, writes it into
// instruction memory and releases the CPU once the checksum matches.
module program_loader #(
  parameter int         MAX_WORDS = 1024,
  parameter logic [7:0] SYNC_BYTE = cpu_pkg::SYNC_BYTE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  import cpu_pkg::*;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  loader_state_t state, state_n;
  logic [15:0] idx, idx_n;
  logic [15:0] len, len_n;
  logic [15:0] idx_inc;
  logic [7:0]  csum, csum_n;
  logic [7:0]  hi, hi_n;
  logic        xfer;
  logic        wr_fire;

  assign rx_ready = (state != DONE) && (state != ERROR);
  assign xfer     = rx_valid && rx_ready;
  assign idx_inc  = idx + 16'd1;

  // Next-state and datapath decode; start overrides any byte this cycle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len;
    csum_n  = csum;
    hi_n    = hi;
    wr_fire = 1'b0;
    if (start) begin
      state_n = IDLE;
      idx_n   = '0;
      csum_n  = '0;
    end else if (xfer) begin
      unique case (state)
        IDLE: begin
          if (rx_data == SYNC_BYTE) state_n = LEN_HI;
        end
        LEN_HI: begin
          len_n   = {rx_data, len[7:0]};
          state_n = LEN_LO;
        end
        LEN_LO: begin
          len_n = {len[15:8], rx_data};
          if (len_n == 16'd0)
            state_n = CHECK;
          else if ({1'b0, len_n} > MAX_LEN)
            state_n = ERROR;
          else
            state_n = DATA_HI;
        end
        DATA_HI: begin
          hi_n    = rx_data;
          csum_n  = csum ^ rx_data;
          state_n = DATA_LO;
        end
        DATA_LO: begin
          csum_n  = csum ^ rx_data;
          wr_fire = 1'b1;
          idx_n   = idx_inc;
          state_n = (idx_inc < len) ? DATA_HI : CHECK;
        end
        CHECK: begin
          state_n = (rx_data == csum) ? DONE : ERROR;
        end
        default: ;
      endcase
    end
  end

  // State, datapath and registered outputs; reset beats start and data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      len      <= '0;
      csum     <= '0;
      hi       <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      len      <= len_n;
      csum     <= csum_n;
      hi       <= hi_n;
      wr_en    <= wr_fire;
      if (wr_fire) begin
        wr_addr <= idx;
        wr_data <= {hi, rx_data};
      end
      done     <= (state_n == DONE);
      error    <= (state_n == ERROR);
      cpu_hold <= (state_n != DONE);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, aborts, bad checksums,
// over-long lengths and mid-frame reset, with writes logged at negedge.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int nwr    = 0;
  int base;

  logic [15:0] wa  [0:63];
  logic [15:0] wd  [0:63];
  logic [15:0] mem [0:15];

  program_loader dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  // Write log: wr_en lasts one full cycle, so each write sees one negedge.
  always @(negedge clock) begin
    if (wr_en) begin
      wa[nwr] = wr_addr;
      wd[nwr] = wr_data;
      mem[wr_addr[3:0]] = wr_data;
      nwr = nwr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    rx_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    rx_valid = 1'b0;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clock);

    chk("rst_wr_en",   32'(wr_en),    32'd0);
    chk("rst_wr_addr", 32'(wr_addr),  32'd0);
    chk("rst_wr_data", 32'(wr_data),  32'd0);
    chk("rst_done",    32'(done),     32'd0);
    chk("rst_error",   32'(error),    32'd0);
    chk("rst_hold",    32'(cpu_hold), 32'd1);
    chk("rst_ready",   32'(rx_ready), 32'd1);
    reset = 1'b0;

    // Two-word frame, checksum 00^01^00^05 = 04
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h00); send(8'h01);
    chk("w0_en",   32'(wr_en),   32'd1);
    chk("w0_addr", 32'(wr_addr), 32'd0);
    chk("w0_data", 32'(wr_data), 32'h0001);
    send(8'h00);
    chk("w0_pulse", 32'(wr_en), 32'd0);
    send(8'h05);
    send(8'h04);
    idle(2);
    chk("f1_nwr",   32'(nwr),      32'd2);
    chk("f1_a1",    32'(wa[1]),    32'd1);
    chk("f1_d1",    32'(wd[1]),    32'h0005);
    chk("f1_done",  32'(done),     32'd1);
    chk("f1_hold",  32'(cpu_hold), 32'd0);
    chk("f1_err",   32'(error),    32'd0);
    chk("f1_ready", 32'(rx_ready), 32'd0);
    chk("f1_haddr", 32'(wr_addr),  32'd1);
    chk("f1_hdata", 32'(wr_data),  32'h0005);

    // Junk byte ahead of an empty frame
    pulse_start();
    chk("st_done", 32'(done),     32'd0);
    chk("st_hold", 32'(cpu_hold), 32'd1);
    chk("st_rdy",  32'(rx_ready), 32'd1);
    base = nwr;
    send(8'h33); send(8'hA5); send(8'h00);
    send(8'h00); send(8'h00);
    idle(2);
    chk("f0_nwr",  32'(nwr - base), 32'd0);
    chk("f0_done", 32'(done),       32'd1);

    // Bad checksum
    pulse_start();
    base = nwr;
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h00); send(8'h01); send(8'h00);
    send(8'h05); send(8'h07);
    idle(2);
    chk("bc_nwr",  32'(nwr - base), 32'd2);
    chk("bc_err",  32'(error),      32'd1);
    chk("bc_done", 32'(done),       32'd0);
    chk("bc_hold", 32'(cpu_hold),   32'd1);
    chk("bc_rdy",  32'(rx_ready),   32'd0);

    // Length 0x0401 exceeds 1024 words
    pulse_start();
    base = nwr;
    send(8'hA5); send(8'h04); send(8'h01);
    chk("ln_err", 32'(error), 32'd1);
    idle(2);
    chk("ln_nwr", 32'(nwr - base), 32'd0);
    chk("ln_rdy", 32'(rx_ready),   32'd0);

    // Abort after the first word, then a full frame
    pulse_start();
    base = nwr;
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22);
    pulse_start();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'hAB); send(8'hCD); send(8'h12);
    send(8'h34); send(8'h40);
    idle(2);
    chk("rs_nwr",  32'(nwr - base), 32'd3);
    chk("rs_m0",   32'(mem[0]),     32'hABCD);
    chk("rs_m1",   32'(mem[1]),     32'h1234);
    chk("rs_done", 32'(done),       32'd1);

    // start on the DATA_LO transfer cancels the write
    pulse_start();
    base = nwr;
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'h77);
    @(negedge clock);
    rx_data  = 8'h88;
    rx_valid = 1'b1;
    start    = 1'b1;
    @(posedge clock);
    #1;
    chk("cx_wr_en", 32'(wr_en), 32'd0);
    @(negedge clock);
    start = 1'b0;
    idle(1);
    chk("cx_nwr",  32'(nwr - base), 32'd0);
    chk("cx_done", 32'(done),       32'd0);

    // Reset while waiting in DATA_HI
    pulse_start();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22);
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    chk("mr_wr_en", 32'(wr_en),    32'd0);
    chk("mr_addr",  32'(wr_addr),  32'd0);
    chk("mr_data",  32'(wr_data),  32'd0);
    chk("mr_hold",  32'(cpu_hold), 32'd1);
    chk("mr_done",  32'(done),     32'd0);
    chk("mr_rdy",   32'(rx_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    base = nwr;
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hBE); send(8'hEF); send(8'h51);
    idle(2);
    chk("mr_nwr",  32'(nwr - base), 32'd1);
    chk("mr_m0",   32'(mem[0]),     32'hBEEF);
    chk("mr_fin",  32'(done),       32'd1);
    chk("mr_err",  32'(error),      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
